pattern_serializer: RTL and testbench

- Downstream consumer of the 8-bit constant/pattern generators in the keyword benchmarks: accepts one `WIDTH`-bit word per handshake and shifts it out as a framed serial stream.
- Frame: start bit, data bits MSB first, parity bit, stop bit.
- Exercises sequential synthesis (FSM, counter, shift register, handshake) in the same Odin II regression suite.
- Parity is computed through an automatic function, so the task/function elaboration path is covered in a clocked context.

---
 rtl/pattern_serializer_pkg.sv | 32 +++
 rtl/serializer_bitcount.sv | 49 ++++
 rtl/pattern_serializer.sv | 144 ++++++++++++++
 tb/tb_pattern_serializer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pattern_serializer_pkg.sv
// ---------------------------------------------------------------------------
// pattern_serializer_pkg
//   Shared definitions for the framed serializer:
//     - DEFAULT_WIDTH : data word width, taken from the WIDTH macro, which
//                       defaults to 8 when not supplied on the command line.
//     - state_e       : serializer FSM state encoding.
//     - cnt_width()   : width of the data-bit down-counter for a word width.
//   No ports (package).
// ---------------------------------------------------------------------------
`ifndef WIDTH
`define WIDTH 8
`endif

package pattern_serializer_pkg;

    localparam int DEFAULT_WIDTH = `WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // The counter only has to hold WIDTH-1 down to 0; keep at least one bit
    // so a degenerate WIDTH=1 build still elaborates.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serializer_bitcount.sv
// ---------------------------------------------------------------------------
// serializer_bitcount
//   Loadable down-counter with a zero flag, used to count data bits of the
//   frame currently on the serial line.
//   Ports:
//     clk          : clock, rising edge
//     rst_n        : asynchronous active-low reset, clears the count
//     load_i       : load load_value_i this cycle (has priority over dec_i)
//     load_value_i : value to load
//     dec_i        : decrement by one; ignored when already zero
//     zero_o       : count is zero (decoded from the register)
// ---------------------------------------------------------------------------
module serializer_bitcount
    import pattern_serializer_pkg::*;
#(
    parameter int CNT_W = cnt_width(DEFAULT_WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_value_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (dec_i && (count_q != '0)) begin
            // Saturate at zero so a stray decrement can never wrap.
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/pattern_serializer.sv
// ---------------------------------------------------------------------------
// pattern_serializer
//   Accepts one WIDTH-bit word per valid/ready handshake and shifts it out as
//   a framed serial stream: start bit (0), data MSB first, parity, stop (1).
//   A frame lasts exactly WIDTH+3 cycles; a word accepted during the stop
//   cycle starts the next frame with no idle gap.
//   Ports:
//     clk        : clock, rising edge
//     rst_n      : asynchronous active-low reset; aborts any frame in flight
//     din        : parallel word, sampled only on the accepting edge
//     din_valid  : din is valid this cycle
//     din_ready  : a word can be accepted this cycle (IDLE or STOP)
//     sout       : serial line, idles high
//     busy       : a frame is in progress (START..STOP)
//     frame_done : one-cycle pulse during the stop bit
//   All outputs are decoded from registered state, never from din.
// ---------------------------------------------------------------------------
module pattern_serializer
    import pattern_serializer_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             busy,
    output logic             frame_done
);

    localparam int CNT_W = cnt_width(WIDTH);

    // Even parity makes the XOR of data+parity zero; odd parity inverts it.
    function automatic logic frame_parity(input logic [WIDTH-1:0] word);
        return (^word) ^ (PARITY_ODD != 0);
    endfunction

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic             parity_q;
    logic             parity_d;

    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;

    serializer_bitcount #(
        .CNT_W (CNT_W)
    ) u_bitcount (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (cnt_load),
        .load_value_i (CNT_W'(WIDTH - 1)),
        .dec_i        (cnt_dec),
        .zero_o       (cnt_zero)
    );

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        sout       = 1'b1;
        din_ready  = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    state_d  = ST_START;
                    shift_d  = din;
                    parity_d = frame_parity(din);
                end
            end

            ST_START: begin
                sout     = 1'b0;
                busy     = 1'b1;
                // Counter holds the number of data bits still to go after
                // the current one, so DATA leaves when it reads zero.
                cnt_load = 1'b1;
                state_d  = ST_DATA;
            end

            ST_DATA: begin
                sout    = shift_q[WIDTH-1];
                busy    = 1'b1;
                shift_d = shift_q << 1;
                if (cnt_zero) begin
                    state_d = ST_PARITY;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            ST_PARITY: begin
                sout    = parity_q;
                busy    = 1'b1;
                state_d = ST_STOP;
            end

            ST_STOP: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                din_ready  = 1'b1;
                if (din_valid) begin
                    // Back-to-back: next start bit follows the stop bit.
                    state_d  = ST_START;
                    shift_d  = din;
                    parity_d = frame_parity(din);
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                // Unused encodings recover to IDLE with the line held high.
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
        end
    end

endmodule

// File: tb/tb_pattern_serializer.sv
// ---------------------------------------------------------------------------
// tb_pattern_serializer
//   Drives an even-parity and an odd-parity serializer from the same inputs
//   and compares both against a frame-level reference: every accepted word
//   appends its whole expected frame (one entry per cycle) to a queue.
// ---------------------------------------------------------------------------
module tb_pattern_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;

    logic sout_e, ready_e, busy_e, done_e;
    logic sout_o, ready_o, busy_o, done_o;

    int checks = 0;
    int errors = 0;

    pattern_serializer #(.WIDTH(8), .PARITY_ODD(0)) dut_even (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (ready_e),
        .sout       (sout_e),
        .busy       (busy_e),
        .frame_done (done_e)
    );

    pattern_serializer #(.WIDTH(8), .PARITY_ODD(1)) dut_odd (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (ready_o),
        .sout       (sout_o),
        .busy       (busy_o),
        .frame_done (done_o)
    );

    always #5 clk = ~clk;

    // One expected cycle of line activity.
    typedef struct packed {
        logic s_e;
        logic s_o;
        logic busy;
        logic ready;
        logic done;
    } exp_t;

    localparam exp_t IDLE_ITEM = '{s_e: 1'b1, s_o: 1'b1, busy: 1'b0, ready: 1'b1, done: 1'b0};

    exp_t q[$];

    function automatic exp_t cur_item();
        if (q.size() == 0) return IDLE_ITEM;
        return q[0];
    endfunction

    task automatic push_frame(input logic [7:0] w);
        exp_t it;
        it = '{s_e: 1'b0, s_o: 1'b0, busy: 1'b1, ready: 1'b0, done: 1'b0};
        q.push_back(it);
        for (int i = 7; i >= 0; i--) begin
            it = '{s_e: w[i], s_o: w[i], busy: 1'b1, ready: 1'b0, done: 1'b0};
            q.push_back(it);
        end
        it = '{s_e: ^w, s_o: ~(^w), busy: 1'b1, ready: 1'b0, done: 1'b0};
        q.push_back(it);
        it = '{s_e: 1'b1, s_o: 1'b1, busy: 1'b1, ready: 1'b1, done: 1'b1};
        q.push_back(it);
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
            $error("check %s", tag);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".sout_even"},  sout_e,  e.s_e);
        chk({tag, ".sout_odd"},   sout_o,  e.s_o);
        chk({tag, ".busy_even"},  busy_e,  e.busy);
        chk({tag, ".busy_odd"},   busy_o,  e.busy);
        chk({tag, ".ready_even"}, ready_e, e.ready);
        chk({tag, ".ready_odd"},  ready_o, e.ready);
        chk({tag, ".done_even"},  done_e,  e.done);
        chk({tag, ".done_odd"},   done_o,  e.done);
    endtask

    // Called just after a falling edge with inputs already set: check the
    // current cycle, advance the model across the rising edge, return at the
    // next falling edge.
    task automatic step(input string tag);
        exp_t e;
        logic acc;
        e = cur_item();
        chk_all(tag, e);
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
        end else begin
            acc = din_valid && e.ready;
            if (q.size() > 0) void'(q.pop_front());
            if (acc) begin
                $display("[%0t] %s: accept din=%h", $time, tag, din);
                push_frame(din);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset held for two cycles, then idle.
        @(negedge clk);
        repeat (2) step("reset");
        rst_n = 1'b1;
        repeat (5) step("idle");

        // Single frame 0xAA.
        din = 8'hAA; din_valid = 1'b1;
        step("single");
        din_valid = 1'b0;
        repeat (13) step("single");

        // All ones: odd instance sends parity 1, even sends 0.
        din = 8'hFF; din_valid = 1'b1;
        step("ones");
        din_valid = 1'b0;
        repeat (13) step("ones");

        // Back-to-back: valid held, second word taken in the stop cycle.
        din = 8'hA5; din_valid = 1'b1;
        step("b2b");
        din = 8'h3C;
        repeat (11) step("b2b");
        din_valid = 1'b0;
        repeat (13) step("b2b");

        // Input changes and valid pulses during DATA are ignored.
        din = 8'h0F; din_valid = 1'b1;
        step("ignore");
        din = 8'hF0; din_valid = 1'b0;
        repeat (2) step("ignore");
        din_valid = 1'b1;
        repeat (3) step("ignore");
        din_valid = 1'b0;
        repeat (10) step("ignore");

        // Asynchronous reset during the 4th data bit.
        din = 8'h5C; din_valid = 1'b1;
        step("midrst");
        din_valid = 1'b0;
        repeat (4) step("midrst");
        #1 rst_n = 1'b0;
        #1;
        chk("midrst.async_sout",  sout_e,  1'b1);
        chk("midrst.async_busy",  busy_e,  1'b0);
        chk("midrst.async_ready", ready_e, 1'b1);
        chk("midrst.async_done",  done_o,  1'b0);
        q.delete();
        @(negedge clk);
        step("midrst");
        rst_n = 1'b1;
        din = 8'hC3; din_valid = 1'b1;
        step("after_rst");
        din_valid = 1'b0;
        repeat (13) step("after_rst");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            din       = 8'($urandom);
            din_valid = ($urandom_range(0, 2) != 0);
            step("random");
        end
        din_valid = 1'b0;
        repeat (13) step("drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
